// File: rtl/cordic_hyp_pkg.sv
// Shared constants for the hyperbolic CORDIC rotation block: datapath format,
// gain-compensation seed, iteration shift schedule and atanh angle table.
package cordic_hyp_pkg;

    localparam int DW      = 22;   // datapath width, signed Q2.20
    localparam int FRAC    = 20;   // datapath fraction bits
    localparam int OUT_W   = 16;   // I/O width, signed Q2.14
    localparam int IN_FRAC = 14;   // I/O fraction bits

    // 1/Kh for the schedule below (repeats at 4 and 13), about 1.207497
    localparam logic signed [DW-1:0] INV_KH = 22'sh1351E3;

    // Counter value parked in while no computation is running
    localparam logic [3:0] CNT_IDLE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    // Shift amount used at iteration cnt; 4 and 13 repeat for convergence
    function automatic logic [3:0] shift_sched(input logic [3:0] cnt);
        logic [3:0] s;
        case (cnt)
            4'd0:    s = 4'd1;
            4'd1:    s = 4'd2;
            4'd2:    s = 4'd3;
            4'd3:    s = 4'd4;
            4'd4:    s = 4'd4;
            4'd5:    s = 4'd5;
            4'd6:    s = 4'd6;
            4'd7:    s = 4'd7;
            4'd8:    s = 4'd8;
            4'd9:    s = 4'd9;
            4'd10:   s = 4'd10;
            4'd11:   s = 4'd11;
            4'd12:   s = 4'd12;
            4'd13:   s = 4'd13;
            4'd14:   s = 4'd13;
            default: s = 4'd14;
        endcase
        return s;
    endfunction

    // atanh(2^-i) in Q2.20, rounded to nearest
    function automatic logic signed [DW-1:0] atanh_tab(input logic [3:0] i);
        logic signed [DW-1:0] a;
        case (i)
            4'd1:    a = 22'sd575989;
            4'd2:    a = 22'sd267820;
            4'd3:    a = 22'sd131761;
            4'd4:    a = 22'sd65622;
            4'd5:    a = 22'sd32779;
            4'd6:    a = 22'sd16385;
            4'd7:    a = 22'sd8192;
            4'd8:    a = 22'sd4096;
            4'd9:    a = 22'sd2048;
            4'd10:   a = 22'sd1024;
            4'd11:   a = 22'sd512;
            4'd12:   a = 22'sd256;
            4'd13:   a = 22'sd128;
            4'd14:   a = 22'sd64;
            default: a = 22'sd0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_hyp_stage.sv
// One hyperbolic CORDIC rotation micro-rotation: direction chosen from the
// sign of the residual angle, all three updates from pre-iteration values.
module cordic_hyp_stage
    import cordic_hyp_pkg::*;
(
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] y,
    input  logic signed [DW-1:0] z,
    input  logic        [3:0]    shift,
    input  logic signed [DW-1:0] angle,
    output logic signed [DW-1:0] x_nx,
    output logic signed [DW-1:0] y_nx,
    output logic signed [DW-1:0] z_nx
);

    logic signed [DW-1:0] xs;
    logic signed [DW-1:0] ys;

    assign xs = x >>> shift;
    assign ys = y >>> shift;

    // Rotate toward zero residual angle
    always_comb begin
        if (!z[DW-1]) begin
            x_nx = x + ys;
            y_nx = y + xs;
            z_nx = z - angle;
        end else begin
            x_nx = x - ys;
            y_nx = y - xs;
            z_nx = z + angle;
        end
    end

endmodule

// File: rtl/cordic_hyp_rot_seq.sv
// Sequential hyperbolic CORDIC in rotation mode: one micro-rotation per clock,
// producing cosh(z) and sinh(z) in Q2.14 seventeen cycles after start.
module cordic_hyp_rot_seq
    import cordic_hyp_pkg::*;
(
    input  logic             clk,
    input  logic             rstx,
    input  logic             start,
    input  logic [OUT_W-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] cosh_out,
    output logic [OUT_W-1:0] sinh_out
);

    localparam int SH = FRAC - IN_FRAC;
    localparam logic signed [OUT_W-1:0] DIN_MAX = 16'sh4000;
    localparam logic signed [OUT_W-1:0] DIN_MIN = 16'shC000;

    state_t               state_q, state_nx;
    logic [3:0]           cnt_q, cnt_nx;
    logic signed [DW-1:0] x_q, y_q, z_q;
    logic signed [DW-1:0] x_nx, y_nx, z_nx;
    logic signed [DW-1:0] x_it, y_it, z_it;
    logic [OUT_W-1:0]     cosh_nx, sinh_nx;
    logic                 done_nx;
    logic [3:0]           shift;

    // Restrict the input angle to |z| <= 1.0 where the iteration converges
    function automatic logic signed [OUT_W-1:0] clamp_din(input logic signed [OUT_W-1:0] d);
        if (d > DIN_MAX) return DIN_MAX;
        if (d < DIN_MIN) return DIN_MIN;
        return d;
    endfunction

    // Q2.20 -> Q2.14, round half up; the clamped range cannot overflow
    function automatic logic [OUT_W-1:0] round_out(input logic signed [DW-1:0] v);
        return v[DW-1:SH] + {{(OUT_W-1){1'b0}}, v[SH-1]};
    endfunction

    assign shift = shift_sched(cnt_q);
    assign busy  = (state_q != S_IDLE);

    cordic_hyp_stage u_stage (
        .x     (x_q),
        .y     (y_q),
        .z     (z_q),
        .shift (shift),
        .angle (atanh_tab(shift)),
        .x_nx  (x_it),
        .y_nx  (y_it),
        .z_nx  (z_it)
    );

    // Next-state, iteration and output-capture decisions; start always wins
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        x_nx     = x_q;
        y_nx     = y_q;
        z_nx     = z_q;
        cosh_nx  = cosh_out;
        sinh_nx  = sinh_out;
        done_nx  = 1'b0;
        if (start) begin
            state_nx = S_RUN;
            cnt_nx   = 4'd0;
            x_nx     = INV_KH;
            y_nx     = '0;
            z_nx     = {clamp_din($signed(din)), {SH{1'b0}}};
        end else begin
            case (state_q)
                S_RUN: begin
                    x_nx = x_it;
                    y_nx = y_it;
                    z_nx = z_it;
                    if (cnt_q == 4'd15) begin
                        state_nx = S_FINISH;
                        cnt_nx   = CNT_IDLE;
                    end else begin
                        cnt_nx = cnt_q + 4'd1;
                    end
                end
                S_FINISH: begin
                    cosh_nx  = round_out(x_q);
                    sinh_nx  = round_out(y_q);
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                    cnt_nx   = CNT_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                    cnt_nx   = CNT_IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstx) begin
            state_q  <= S_IDLE;
            cnt_q    <= CNT_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            cosh_out <= '0;
            sinh_out <= '0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_nx;
            cnt_q    <= cnt_nx;
            x_q      <= x_nx;
            y_q      <= y_nx;
            z_q      <= z_nx;
            cosh_out <= cosh_nx;
            sinh_out <= sinh_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: doc/cordic_hyp_rot_seq.md
CORDIC_HYP_ROT_SEQ -- requirements
Module: cordic_hyp_rot_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk, rstx.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rstx  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 Port: start  input  1  single-cycle request; latches din and begins a computation.
REQ-005 Port: din  input  16  hyperbolic angle z, signed Q2.14.
REQ-006 Port: busy  output  1  high while a computation is in progress.
REQ-007 Port: done  output  1  one-cycle pulse; cosh_out/sinh_out valid from this cycle.
REQ-008 Port: cosh_out  output  16  cosh(z), signed Q2.14.
REQ-009 Port: sinh_out  output  16  sinh(z), signed Q2.14.

Function
REQ-010 The block SHALL compute cosh/sinh by CORDIC hyperbolic rotation mode, the inverse direction of the team's hyperbolic vectoring sqrt.
REQ-011 Datapath registers x, y, z SHALL be 22-bit signed Q2.20; all shifts arithmetic.
REQ-012 On start: z <= din sign-extended to Q2.20 (din<<6); x <= 0x1351E3 (1/Kh ≈ 1.207497); y <= 0; cnt <= 0.
REQ-013 Input clamp: din > 0x4000 SHALL be treated as 0x4000; din < 0xC000 SHALL be treated as 0xC000 (|z| ≤ 1.0).
REQ-014 Shift schedule for cnt 0..15 SHALL be i = 1,2,3,4,4,5,6,7,8,9,10,11,12,13,13,14 (repeats at 4 and 13).
REQ-015 Each iteration with z ≥ 0: x += y>>>i, y += x>>>i, z -= atanh(2^-i); with z < 0: x -= y>>>i, y -= x>>>i, z += atanh(2^-i). All updates SHALL use pre-iteration values.
REQ-016 atanh(2^-i) constants SHALL be Q2.20, rounded to nearest.
REQ-017 Counter states: IDLE (cnt=0xF, no iteration), RUN (cnt 0..15, one iteration per cycle), FINISH (one cycle: round, register outputs, pulse done).
REQ-018 Latency: start accepted at edge T; iterations at edges T+1..T+16; outputs and done registered at edge T+17.
REQ-019 busy SHALL be high from the cycle after start through the cycle before done, and low in the done cycle.
REQ-020 Output rounding: out = bits[21:6] + bit[5] (round half up), no saturation needed within the clamped range.
REQ-021 cosh_out/sinh_out SHALL hold their value until the next done pulse.
REQ-022 start while busy SHALL abort the current computation and restart with the new din; no done for the aborted one.
REQ-023 start in the done cycle SHALL be accepted; the completed outputs SHALL still be presented.
REQ-024 Accuracy: |error| ≤ 2 LSB (Q2.14) over the clamped range.

Reset
REQ-025 On rstx=0 at a clk edge: cnt=IDLE, x=y=z=0, busy=0, done=0, cosh_out=0, sinh_out=0.
REQ-026 Reset SHALL take priority over start, and reset mid-computation SHALL discard it with no done.

Structure
REQ-027 Package cordic_hyp_pkg SHALL hold the datapath width (22), fraction bits (20), the 1/Kh constant, the 16-entry shift schedule and the atanh table.
REQ-028 One combinational sub-module cordic_hyp_stage (x, y, z, shift, angle -> next x, y, z) SHALL implement REQ-015; iteration control SHALL stay in the top module.

Verification
REQ-029 din=0x0000 -> done at T+17; cosh_out=0x4000, sinh_out=0x0000 (±2 LSB).
REQ-030 din=0x4000 -> cosh_out≈0x62C2, sinh_out≈0x4B36; din=0xC000 -> cosh_out≈0x62C2, sinh_out≈0xB4CA.
REQ-031 din=0x2000 -> cosh_out≈0x482B, sinh_out≈0x215A; din=0x7FFF -> same result as 0x4000 (clamp).
REQ-032 start 0x2000, second start 0x4000 at T+8 -> single done at T+8+17 with the 0x4000 results; busy never drops in between.
REQ-033 rstx low at T+10 of a run -> no done; all outputs 0 the following cycle; next start completes normally.
REQ-034 Random sweep of 1000 din values -> every result within 2 LSB of a double-precision model; cosh_out ≥ 0x4000 always.
